// File: rtl/complemento_pkg.sv
// Shared encodings for the bit-serial complement unit: operand modes and FSM states.
package complemento_pkg;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_ONES = 2'b01;
   localparam logic [1:0] MODE_TWOS = 2'b10;
   localparam logic [1:0] MODE_ABS  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Initial {invert, carry} for the serial cell; abs negates only negative operands.
   function automatic logic [1:0] seed_inv_carry(input logic [1:0] mode, input logic msb);
      logic [1:0] seed;
      seed = 2'b00;
      case (mode)
         MODE_PASS: seed = 2'b00;
         MODE_ONES: seed = 2'b10;
         MODE_TWOS: seed = 2'b11;
         default:   seed = {msb, msb};
      endcase
      return seed;
   endfunction

endpackage

// File: rtl/complemento_serial_if.sv
// Operand and result valid/ready channels of the bit-serial complement unit.
interface complemento_serial_if #(parameter int unsigned WIDTH = 6);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic             out_zero;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_zero
   );

endinterface

// File: rtl/complemento_bit_cell.sv
// One complement/carry stage: optional inversion followed by a half-adder with the running carry.
module complemento_bit_cell (
   input  logic b,
   input  logic inv,
   input  logic cin,
   output logic r,
   output logic cout
);

   logic t;

   assign t    = b ^ inv;
   assign r    = t ^ cin;
   assign cout = t & cin;

endmodule

// File: rtl/complemento_serial.sv
// Bit-serial pass/ones'/two's/abs unit: one operand bit per clock, LSB first, through a single cell.
module complemento_serial
   import complemento_pkg::*;
#(
   parameter int unsigned WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   complemento_serial_if.slave bus
);

   localparam int unsigned      CNT_W   = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t state_q, state_d;

   logic             accept, shift_en, last_bit;
   logic [WIDTH-1:0] op_q, res_q, res_next;
   logic [CNT_W-1:0] cnt_q;
   logic             inv_q, carry_q, ovf_pend_q;
   logic             r_bit, cout_bit;

   logic             in_ready_q, out_valid_q, out_ovf_q, out_zero_q;
   logic [WIDTH-1:0] out_data_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (bus.in_valid)                  state_d = ST_SHIFT;
         ST_SHIFT: if (cnt_q == CNT_W'(WIDTH - 1))    state_d = ST_DONE;
         ST_DONE:  if (bus.out_ready)                 state_d = ST_IDLE;
         default:                                     state_d = ST_IDLE;
      endcase
   end

   // Datapath controls decoded from the current state
   always_comb begin
      accept   = 1'b0;
      shift_en = 1'b0;
      last_bit = 1'b0;
      unique case (state_q)
         ST_IDLE:  accept   = bus.in_valid;
         ST_SHIFT: begin
            shift_en = 1'b1;
            last_bit = (cnt_q == CNT_W'(WIDTH - 1));
         end
         ST_DONE:  ;
         default:  ;
      endcase
   end

   complemento_bit_cell u_cell (
      .b    (op_q[0]),
      .inv  (inv_q),
      .cin  (carry_q),
      .r    (r_bit),
      .cout (cout_bit)
   );

   assign res_next = {r_bit, res_q[WIDTH-1:1]};

   // Operand/result shift registers, carry and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
         inv_q      <= 1'b0;
         carry_q    <= 1'b0;
         ovf_pend_q <= 1'b0;
      end else if (accept) begin
         op_q             <= bus.in_data;
         res_q            <= '0;
         cnt_q            <= '0;
         {inv_q, carry_q} <= seed_inv_carry(bus.in_mode, bus.in_data[WIDTH-1]);
         ovf_pend_q       <= ((bus.in_mode == MODE_TWOS) || (bus.in_mode == MODE_ABS))
                             && (bus.in_data == MIN_NEG);
      end else if (shift_en) begin
         op_q    <= op_q >> 1;
         res_q   <= res_next;
         carry_q <= cout_bit;
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

   // Registered handshake outputs follow the next state; result and flags load on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_zero_q  <= 1'b0;
      end else begin
         in_ready_q  <= (state_d == ST_IDLE);
         out_valid_q <= (state_d == ST_DONE);
         if (last_bit) begin
            out_data_q <= res_next;
            out_ovf_q  <= ovf_pend_q;
            out_zero_q <= (res_next == '0);
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;
   assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_complemento_serial.sv
// Self-checking bench for complemento_serial: directed cases, random operands, backpressure, reset abort, streaming.
module tb_complemento_serial;

   localparam int unsigned W = 6;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   complemento_serial_if #(.WIDTH(W)) bus ();

   complemento_serial #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {ovf, zero, result} from plain modular arithmetic
   function automatic logic [W+1:0] model(input logic [1:0] m, input logic [W-1:0] d);
      logic [W-1:0] neg, r;
      logic         ovf;
      neg = W'((32'd1 << W) - 32'(d));
      case (m)
         2'b00:   r = d;
         2'b01:   r = ~d;
         2'b10:   r = neg;
         default: r = (32'(d) >= (32'd1 << (W - 1))) ? neg : d;
      endcase
      ovf = m[1] && (32'(d) == (32'd1 << (W - 1)));
      return {ovf, (r == '0), r};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; bp = cycles of out_ready low while the result is held
   task automatic run_op(input logic [1:0] m, input logic [W-1:0] d, input int bp);
      logic [W+1:0]  exp;
      logic [W-1:0]  held;
      int            lat;
      exp = model(m, d);
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_mode   = m;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = W'($urandom);
      bus.in_mode  = 2'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'(W));
      check("out_data", 32'(bus.out_data), 32'(exp[W-1:0]));
      check("out_zero", 32'(bus.out_zero), 32'(exp[W]));
      check("out_ovf",  32'(bus.out_ovf),  32'(exp[W+1]));
      held = bus.out_data;
      for (int i = 0; i < bp; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = W'($urandom);
         tick();
         check("bp_valid", 32'(bus.out_valid), 32'd1);
         check("bp_data",  32'(bus.out_data), 32'(held));
         check("bp_flags", {30'd0, bus.out_ovf, bus.out_zero}, {30'd0, exp[W+1], exp[W]});
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("valid_drop", 32'(bus.out_valid), 32'd0);
      check("ready_back", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;
   endtask

   logic [W+1:0] exp_q[$];
   logic [W+1:0] e;
   int           last_acc;
   int           n_acc;

   initial begin
      compared      = 0;
      mismatched    = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 2'b00;
      bus.out_ready = 1'b0;

      #12;
      check("rst_in_ready",  32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_outs", {23'd0, bus.out_ovf, bus.out_zero, 1'b0, bus.out_data}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Directed cases
      run_op(2'b10, 6'b001010, 0);
      run_op(2'b10, 6'b000000, 0);
      run_op(2'b10, 6'b100000, 0);
      run_op(2'b11, 6'b100000, 1);
      run_op(2'b01, 6'b001010, 0);
      run_op(2'b00, 6'b001010, 0);
      run_op(2'b11, 6'b110110, 0);
      run_op(2'b11, 6'b000101, 0);
      run_op(2'b01, 6'b111111, 0);
      run_op(2'b00, 6'b100000, 0);
      run_op(2'b10, 6'b001010, 5);

      // Random operands and modes
      for (int i = 0; i < 24; i++)
         run_op(2'($urandom), W'($urandom), int'($urandom_range(0, 2)));

      // Reset in the middle of a shift
      run_op(2'b10, 6'b010101, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 6'b011011;
      bus.in_mode  = 2'b10;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_outs", {23'd0, bus.out_ovf, bus.out_zero, 1'b0, bus.out_data}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("abort_no_valid", 32'(bus.out_valid), 32'd0);
      run_op(2'b10, 6'b000011, 0);

      // Streaming with both handshakes held high
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      last_acc = -1;
      n_acc    = 0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("stream_spurious", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("stream_data", 32'(bus.out_data), 32'(e[W-1:0]));
               check("stream_flags", {30'd0, bus.out_ovf, bus.out_zero}, {30'd0, e[W+1], e[W]});
            end
         end
         bus.in_data = W'($urandom);
         bus.in_mode = 2'($urandom);
         if (bus.in_ready) begin
            exp_q.push_back(model(bus.in_mode, bus.in_data));
            if (last_acc >= 0) check("stream_interval", 32'(cyc - last_acc), 32'(W + 2));
            last_acc = cyc;
            n_acc++;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         if (bus.out_valid) begin
            e = exp_q.pop_front();
            check("drain_data", 32'(bus.out_data), 32'(e[W-1:0]));
         end
         tick();
      end
      check("stream_accepts", 32'(n_acc), 32'd8);
      check("stream_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/complemento_serial.md
Name: complemento_serial

Overview:
- Parametrised, bit-serial complement unit. It is the sequential successor to the 6-bit ripple two's-complement negator.
- Accepts a WIDTH-bit operand over a valid/ready handshake and processes one bit per clock, LSB first, through a single complement/carry cell.
- Returns the result with overflow and zero flags over a second valid/ready handshake.
- Four modes: pass, ones' complement, two's complement, absolute value.
- Sits between operand registers and the ALU datapath wherever area matters more than latency.

Parameters:
- WIDTH, 6, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand offered
- in_ready  output  1  unit idle, can accept
- in_data  input  WIDTH  operand
- in_mode  input  2  00 pass, 01 ones', 10 two's, 11 abs
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- out_ovf  output  1  two's/abs of most-negative value
- out_zero  output  1  out_data == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shift/result registers=0, bit counter=0, carry=0, out_valid=0, out_ovf=0, out_zero=0, out_data=0.
- in_ready=1 whenever state==IDLE, including during reset. No capture occurs while rst_n is low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on an edge with in_valid & in_ready. That edge captures:
  - operand into the shift register;
  - mode;
  - inv/carry: pass inv=0 carry=0; ones' inv=1 carry=0; two's inv=1 carry=1; abs inv=in_data[WIDTH-1] carry=in_data[WIDTH-1];
  - ovf_pending = (mode is two's or abs) & (in_data == 1 followed by WIDTH-1 zeros);
  - counter cleared.
- SHIFT, each edge:
  - t = op[0] ^ inv; r = t ^ carry; carry <= t & carry.
  - Result register shifts right with r entering at bit WIDTH-1; operand shifts right.
  - Counter increments.
  - Transition to DONE on the edge where counter reaches WIDTH-1, i.e. the WIDTH-th processing edge.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- DONE:
  - out_valid=1; out_data, out_ovf (=ovf_pending) and out_zero are held stable while out_ready=0.
  - DONE -> IDLE on an edge with out_valid & out_ready. out_valid drops after that edge.
  - in_ready=0 in DONE; no same-cycle accept.
  - Minimum issue interval: WIDTH+2 cycles.
- Outputs are registered. out_data and flags change only on entry to DONE or reset.
- Arithmetic is modulo 2^WIDTH. Final carry-out is discarded.
  - Two's of 0 gives 0 with ovf=0.
  - Two's/abs of 100..0 gives 100..0 with ovf=1.
  - Pass and ones' modes never set ovf.
- in_valid and in_data are ignored outside IDLE. in_mode is sampled only on the accepting edge.
- Reset mid-SHIFT or mid-DONE aborts the operation. No out_valid is produced for it, and the unit is ready one cycle after rst_n rises.

Decomposition:
- Package complemento_pkg holds:
  - mode encodings MODE_PASS=2'b00, MODE_ONES=2'b01, MODE_TWOS=2'b10, MODE_ABS=2'b11;
  - FSM state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One combinational sub-module, complemento_bit_cell: inputs b, inv, cin; outputs r, cout.
- Everything else lives in complemento_serial.

Test Plan:
- WIDTH=6, two's, in_data=001010 -> out_data=110110, ovf=0, zero=0; out_valid exactly 6 cycles after accept.
- Two's of 000000 -> 000000, zero=1, ovf=0. Two's of 100000 -> 100000, ovf=1.
- Ones' of 001010 -> 110101. Pass of 001010 -> 001010. Abs of 110110 -> 001010. Abs of 000101 -> 000101.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data and flags stable, in_ready=0. New in_valid is ignored until the result is taken.
- Reset pulse mid-SHIFT (after 3 bits) -> all outputs 0 immediately, in_ready=1. The next operand 000011 in two's mode -> 111101.
- Back-to-back: out_ready tied 1, in_valid tied 1 -> one accept every 8 cycles, with results in operand order.
